// File: rtl/mode_pkg.sv
// Shared types and helpers for the mode_1 burst sequencer family.
package mode_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    WAIT_F = 2'd2
  } state_e;

  localparam int DEF_LEN_W = 4;
  localparam int DEF_F_TMO = 4;
  localparam int MAX_REQ   = 8;

  // One-hot decode of a requester index; callers truncate to their own width.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mode_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap.
module mode_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] masked;

  // Duplicate the request vector, keep only the N_REQ positions after ptr, take the lowest.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    any    = 1'b0;
    idx    = '0;
    for (int j = 0; j < 2*N_REQ; j++) begin
      if ((j > int'(ptr)) && (j <= int'(ptr) + N_REQ)) begin
        masked[j] = dbl[j];
      end
    end
    for (int j = 2*N_REQ-1; j >= 0; j--) begin
      if (masked[j]) begin
        any = 1'b1;
        idx = IDX_W'(j % N_REQ);
      end
    end
  end

endmodule

// File: rtl/mode_seq.sv
// Burst sequencer and round-robin arbiter sharing one mode_1 FSM among N_REQ requesters.
module mode_seq import mode_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int LEN_W = DEF_LEN_W,
  parameter int F_TMO = DEF_F_TMO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   do_o,
  input  logic                   f_i,
  output logic                   busy,
  output logic                   err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TMO_W = $clog2(F_TMO);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(F_TMO - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               do_q;
  logic               err_q;

  logic               pickAny;
  logic [IDX_W-1:0]   pickIdx;
  logic [LEN_W-1:0]   pickLen;
  logic [N_REQ-1:0]   pickOneHot;

  mode_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pickAny),
    .idx (pickIdx)
  );

  // Burst length and grant vector belonging to the current round-robin winner.
  always_comb begin
    pickLen    = len[pickIdx*LEN_W +: LEN_W];
    pickOneHot = N_REQ'(onehot(3'(pickIdx)));
  end

  // Sequencer FSM; a grant is withheld while done is high so mode_1 gets an extra idle edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
      tmo_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      do_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if ((done_q == '0) && pickAny) begin
            gnt_q   <= pickOneHot;
            ptr_q   <= pickIdx;
            cnt_q   <= pickLen;
            do_q    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cnt_q == '0) begin
            do_q    <= 1'b0;
            tmo_q   <= '0;
            state_q <= WAIT_F;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        WAIT_F: begin
          if (f_i || (tmo_q == TMO_LAST)) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            state_q <= IDLE;
            if (!f_i) begin
              err_q <= 1'b1;
            end
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign do_o = do_q;
  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule
